// File: rtl/square_sched_pkg.sv
// rtl/square_sched_pkg.sv - shared types and constants for the square/multiply scheduler
package square_sched_pkg;

    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_MUL_LATENCY = 3;
    // Tag channel field is sized for the largest supported channel count (16).
    localparam int MAX_CW          = 4;

    typedef struct packed {
        logic              valid;
        logic [MAX_CW-1:0] ch;
    } tag_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter searching upward from ptr with wrap
module rr_arbiter
    import square_sched_pkg::*;
#(
    parameter int  N  = DEF_NUM_CH,
    localparam int CW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [CW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [CW-1:0] gnt_idx
);

    int   idx;
    logic found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = CW'(idx);
            end
        end
    end

endmodule

// File: rtl/square_scheduler.sv
// rtl/square_scheduler.sv - time-shares one fixed-latency multiplier between NUM_CH channels
module square_scheduler
    import square_sched_pkg::*;
#(
    parameter int  NUM_CH         = DEF_NUM_CH,
    parameter int  SRC_DATA_WIDTH = 16,
    parameter int  MUL_LATENCY    = DEF_MUL_LATENCY,
    localparam int CW             = clog2(NUM_CH),
    localparam int W              = SRC_DATA_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hold,
    input  logic [NUM_CH-1:0]   req_valid,
    input  logic [NUM_CH*W-1:0] req_src0,
    input  logic [NUM_CH*W-1:0] req_src1,
    output logic [NUM_CH-1:0]   req_ready,
    output logic                mul_valid,
    output logic [W-1:0]        mul_src0,
    output logic [W-1:0]        mul_src1,
    input  logic [2*W-1:0]      mul_res,
    output logic                res_valid,
    output logic [CW-1:0]       res_ch,
    output logic [2*W-1:0]      res_data,
    output logic                busy
);

    logic [CW-1:0]     ptr;
    logic [CW-1:0]     gnt_idx;
    logic [NUM_CH-1:0] gnt;
    logic              grant;
    logic              tag_any;
    tag_t              tags [MUL_LATENCY];

    // Reset and hold both suppress the grant so req_ready stays low combinationally.
    rr_arbiter #(.N(NUM_CH)) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .en      (!rst && !hold),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign grant     = |gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            mul_valid <= 1'b0;
            mul_src0  <= '0;
            mul_src1  <= '0;
            res_valid <= 1'b0;
            res_ch    <= '0;
            res_data  <= '0;
            for (int k = 0; k < MUL_LATENCY; k++) begin
                tags[k] <= '0;
            end
        end else begin
            mul_valid <= grant;
            if (grant) begin
                ptr      <= (gnt_idx == CW'(NUM_CH - 1)) ? '0 : gnt_idx + CW'(1);
                mul_src0 <= req_src0[int'(gnt_idx)*W +: W];
                mul_src1 <= req_src1[int'(gnt_idx)*W +: W];
            end
            tags[0] <= '{valid: grant, ch: MAX_CW'(gnt_idx)};
            for (int k = 1; k < MUL_LATENCY; k++) begin
                tags[k] <= tags[k-1];
            end
            // The last tag stage lines up with the product on mul_res.
            res_valid <= tags[MUL_LATENCY-1].valid;
            if (tags[MUL_LATENCY-1].valid) begin
                res_ch   <= CW'(tags[MUL_LATENCY-1].ch);
                res_data <= mul_res;
            end
        end
    end

    always_comb begin
        tag_any = 1'b0;
        for (int k = 0; k < MUL_LATENCY; k++) begin
            tag_any = tag_any | tags[k].valid;
        end
    end

    assign busy = mul_valid | tag_any | res_valid;

endmodule

// File: tb/tb_square_scheduler.sv
// tb/tb_square_scheduler.sv - randomized self-checking bench for square_scheduler
module tb_square_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold;
    logic [3:0]  req_valid;
    logic [63:0] req_src0;
    logic [63:0] req_src1;
    logic [3:0]  req_ready;
    logic        mul_valid;
    logic [15:0] mul_src0;
    logic [15:0] mul_src1;
    logic [31:0] mul_res;
    logic        res_valid;
    logic [1:0]  res_ch;
    logic [31:0] res_data;
    logic        busy;

    logic        hold_w;
    logic [3:0]  req_valid_w;
    logic [63:0] req_src0_w;
    logic [63:0] req_src1_w;
    logic [3:0]  req_ready_w;
    logic        mul_valid_w;
    logic [15:0] mul_src0_w;
    logic [15:0] mul_src1_w;
    logic [31:0] mul_res_w;
    logic        res_valid_w;
    logic [1:0]  res_ch_w;
    logic [31:0] res_data_w;
    logic        busy_w;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    square_scheduler dut (
        .clk(clk), .rst(rst), .hold(hold), .req_valid(req_valid),
        .req_src0(req_src0), .req_src1(req_src1), .req_ready(req_ready),
        .mul_valid(mul_valid), .mul_src0(mul_src0), .mul_src1(mul_src1),
        .mul_res(mul_res), .res_valid(res_valid), .res_ch(res_ch),
        .res_data(res_data), .busy(busy)
    );

    square_scheduler #(.NUM_CH(4), .SRC_DATA_WIDTH(16), .MUL_LATENCY(1)) dut_w (
        .clk(clk), .rst(rst), .hold(hold_w), .req_valid(req_valid_w),
        .req_src0(req_src0_w), .req_src1(req_src1_w), .req_ready(req_ready_w),
        .mul_valid(mul_valid_w), .mul_src0(mul_src0_w), .mul_src1(mul_src1_w),
        .mul_res(mul_res_w), .res_valid(res_valid_w), .res_ch(res_ch_w),
        .res_data(res_data_w), .busy(busy_w)
    );

    // Multiplier models: the operand register is the first latency stage.
    logic [31:0] mp0, mp1;
    always @(posedge clk) begin
        mp0 <= {16'd0, mul_src0} * {16'd0, mul_src1};
        mp1 <= mp0;
    end
    assign mul_res   = mp1;
    assign mul_res_w = {16'd0, mul_src0_w} * {16'd0, mul_src1_w};

    typedef struct {
        logic [1:0]  ch;
        logic [31:0] data;
        int          due;
    } ent_t;

    ent_t        sb [$];
    ent_t        e;
    bit          mon_en   = 1'b0;
    int          cyc      = 0;
    int          mptr     = 0;
    int          mj;
    int          mg;
    bit          prev_acc = 1'b0;
    logic [15:0] prev_a, prev_b;
    logic [3:0]  exp_rdy;
    logic        exp_busy;

    // Scoreboard: sampled 1ns before each rising edge.
    always @(negedge clk) begin
        #4;
        if (mon_en) begin
            exp_busy = (sb.size() != 0);
            total++;
            if (mul_valid !== prev_acc) begin
                bad++;
                $display("FAIL mon_mul_valid cyc=%0d got=%b want=%b", cyc, mul_valid, prev_acc);
            end
            if (prev_acc) begin
                total++;
                if (mul_src0 !== prev_a || mul_src1 !== prev_b) begin
                    bad++;
                    $display("FAIL mon_mul_src cyc=%0d got=%h,%h want=%h,%h", cyc, mul_src0, mul_src1, prev_a, prev_b);
                end
            end
            total++;
            if (sb.size() != 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                if (res_valid !== 1'b1 || res_ch !== e.ch || res_data !== e.data) begin
                    bad++;
                    $display("FAIL mon_result cyc=%0d got=%b/%0d/%h want=1/%0d/%h", cyc, res_valid, res_ch, res_data, e.ch, e.data);
                end
            end else if (res_valid !== 1'b0) begin
                bad++;
                $display("FAIL mon_spurious_res cyc=%0d got res_valid=%b want 0", cyc, res_valid);
            end
            total++;
            if (busy !== exp_busy) begin
                bad++;
                $display("FAIL mon_busy cyc=%0d got=%b want=%b", cyc, busy, exp_busy);
            end
            exp_rdy = 4'b0000;
            mg      = -1;
            if (!rst && !hold) begin
                for (int k = 0; k < 4; k++) begin
                    mj = (mptr + k) % 4;
                    if (mg < 0 && req_valid[mj]) mg = mj;
                end
            end
            if (mg >= 0) exp_rdy[mg] = 1'b1;
            total++;
            if (req_ready !== exp_rdy) begin
                bad++;
                $display("FAIL mon_req_ready cyc=%0d got=%b want=%b", cyc, req_ready, exp_rdy);
            end
            if (rst) begin
                sb.delete();
                mptr     = 0;
                prev_acc = 1'b0;
            end else begin
                prev_acc = (mg >= 0);
                if (mg >= 0) begin
                    prev_a  = req_src0[mg*16 +: 16];
                    prev_b  = req_src1[mg*16 +: 16];
                    e.ch    = 2'(mg);
                    e.data  = {16'd0, prev_a} * {16'd0, prev_b};
                    e.due   = cyc + 4;
                    sb.push_back(e);
                    mptr = (mg + 1) % 4;
                end
            end
        end
        cyc++;
    end

    task automatic set_ops(input int ch, input logic [15:0] a, input logic [15:0] b);
        req_src0[ch*16 +: 16] = a;
        req_src1[ch*16 +: 16] = b;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; hold = 1'b0; req_valid = 4'b1111;
        req_src0 = {$urandom, $urandom}; req_src1 = {$urandom, $urandom};
        repeat (2) @(negedge clk);
        #4;
        total++;
        if (req_ready !== 4'b0000 || mul_valid !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl got rdy=%b mv=%b rv=%b busy=%b want 0", req_ready, mul_valid, res_valid, busy);
        end
        total++;
        if (mul_src0 !== 16'd0 || mul_src1 !== 16'd0 || res_ch !== 2'd0 || res_data !== 32'd0) begin
            bad++;
            $display("FAIL reset_data got %h %h %0d %h want zeros", mul_src0, mul_src1, res_ch, res_data);
        end
        total++;
        if (res_valid_w !== 1'b0 || busy_w !== 1'b0 || req_ready_w !== 4'b0000) begin
            bad++;
            $display("FAIL reset_w got rv=%b busy=%b rdy=%b want 0", res_valid_w, busy_w, req_ready_w);
        end
        mon_en = 1'b1;
        @(negedge clk);
        rst = 1'b0; req_valid = 4'b0000;
    endtask

    task automatic test_single();
        @(negedge clk);
        req_valid = 4'b0100; set_ops(2, 16'd5, 16'd7);
        #4;
        total++;
        if (req_ready !== 4'b0100) begin
            bad++; $display("FAIL single_ready got=%b want=0100", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        #4;
        total++;
        if (mul_valid !== 1'b1 || mul_src0 !== 16'd5 || mul_src1 !== 16'd7) begin
            bad++; $display("FAIL single_mul got=%b %0d %0d want=1 5 7", mul_valid, mul_src0, mul_src1);
        end
        repeat (2) @(negedge clk);
        #4;
        total++;
        if (res_valid !== 1'b0) begin
            bad++; $display("FAIL single_early got res_valid=%b want 0", res_valid);
        end
        @(negedge clk);
        #4;
        total++;
        if (res_valid !== 1'b1 || res_ch !== 2'd2 || res_data !== 32'd35) begin
            bad++; $display("FAIL single_res got=%b/%0d/%0d want=1/2/35", res_valid, res_ch, res_data);
        end
        idle(3);
    endtask

    task automatic test_all_four();
        int         cnt [4];
        int         ord_err;
        logic [3:0] one;
        one = 4'b0001;
        ord_err = 0;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        @(negedge clk);
        rst = 1'b1; req_valid = 4'b1111;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            rst = 1'b0;
            req_src0 = {$urandom, $urandom}; req_src1 = {$urandom, $urandom};
            #4;
            if (req_ready !== (one << (k % 4))) ord_err++;
            for (int i = 0; i < 4; i++) cnt[i] += int'(req_ready[i]);
        end
        total++;
        if (ord_err != 0) begin
            bad++; $display("FAIL all_order got %0d out-of-order grants want 0", ord_err);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (cnt[i] != 25) begin
                bad++; $display("FAIL all_count ch%0d got=%0d want=25", i, cnt[i]);
            end
        end
        @(negedge clk);
        req_valid = 4'b0000;
        idle(6);
    endtask

    task automatic test_ptr2();
        logic [3:0] want [3];
        want[0] = 4'b1000; want[1] = 4'b0010; want[2] = 4'b1000;
        @(negedge clk);
        req_valid = 4'b0010;
        #4;
        total++;
        if (req_ready !== 4'b0010) begin
            bad++; $display("FAIL ptr2_setup got=%b want=0010", req_ready);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req_valid = 4'b1010;
            #4;
            total++;
            if (req_ready !== want[k]) begin
                bad++; $display("FAIL ptr2_grant%0d got=%b want=%b", k, req_ready, want[k]);
            end
        end
        @(negedge clk);
        req_valid = 4'b0000;
        idle(6);
    endtask

    task automatic test_hold();
        int nres;
        nres = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req_valid = 4'b0001;
            set_ops(0, 16'($urandom), 16'($urandom));
            #4;
            total++;
            if (req_ready !== 4'b0001) begin
                bad++; $display("FAIL hold_pre%0d got=%b want=0001", k, req_ready);
            end
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            hold = 1'b1;
            #4;
            total++;
            if (req_ready !== 4'b0000) begin
                bad++; $display("FAIL hold_ready%0d got=%b want=0000", k, req_ready);
            end
            nres += int'(res_valid);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL hold_drain got busy=%b want 0", busy);
        end
        total++;
        if (nres != 3) begin
            bad++; $display("FAIL hold_results got=%0d want=3", nres);
        end
        @(negedge clk);
        hold = 1'b0; req_valid = 4'b1111;
        #4;
        total++;
        if (req_ready !== 4'b0010) begin
            bad++; $display("FAIL hold_ptr got=%b want=0010", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        idle(6);
    endtask

    task automatic test_reset_mid();
        int         nres;
        logic [3:0] want [3];
        want[0] = 4'b0100; want[1] = 4'b1000; want[2] = 4'b0001;
        nres = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req_valid = 4'b1111;
            req_src0 = {$urandom, $urandom}; req_src1 = {$urandom, $urandom};
            #4;
            total++;
            if (req_ready !== want[k]) begin
                bad++; $display("FAIL rstmid_grant%0d got=%b want=%b", k, req_ready, want[k]);
            end
        end
        @(negedge clk);
        req_valid = 4'b0000; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #4;
        total++;
        if (mul_valid !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0 || res_ch !== 2'd0
            || res_data !== 32'd0 || mul_src0 !== 16'd0 || mul_src1 !== 16'd0) begin
            bad++;
            $display("FAIL rstmid_values got mv=%b rv=%b busy=%b ch=%0d d=%h s=%h,%h want zeros",
                     mul_valid, res_valid, busy, res_ch, res_data, mul_src0, mul_src1);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #4;
            nres += int'(res_valid);
        end
        total++;
        if (nres != 0) begin
            bad++; $display("FAIL rstmid_discard got %0d results want 0", nres);
        end
        @(negedge clk);
        req_valid = 4'b1111;
        #4;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++; $display("FAIL rstmid_ptr got=%b want=0001", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        idle(6);
    endtask

    task automatic test_wide();
        @(negedge clk);
        req_valid_w = 4'b0001;
        req_src0_w[15:0] = 16'h8000; req_src1_w[15:0] = 16'h8000;
        #4;
        total++;
        if (req_ready_w !== 4'b0001) begin
            bad++; $display("FAIL wide_ready got=%b want=0001", req_ready_w);
        end
        @(negedge clk);
        req_valid_w = 4'b0000;
        #4;
        total++;
        if (mul_valid_w !== 1'b1 || mul_src0_w !== 16'h8000 || res_valid_w !== 1'b0) begin
            bad++; $display("FAIL wide_mul got mv=%b src=%h rv=%b want 1 8000 0", mul_valid_w, mul_src0_w, res_valid_w);
        end
        @(negedge clk);
        #4;
        total++;
        if (res_valid_w !== 1'b1 || res_ch_w !== 2'd0 || res_data_w !== 32'h40000000) begin
            bad++; $display("FAIL wide_res got=%b/%0d/%h want=1/0/40000000", res_valid_w, res_ch_w, res_data_w);
        end
        idle(3);
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            req_valid = 4'($urandom);
            hold      = ($urandom_range(0, 4) == 0);
            req_src0  = {$urandom, $urandom};
            req_src1  = {$urandom, $urandom};
        end
        @(negedge clk);
        req_valid = 4'b0000; hold = 1'b0;
        idle(8);
        #4;
        total++;
        if (sb.size() != 0 || busy !== 1'b0) begin
            bad++; $display("FAIL random_drain got pending=%0d busy=%b want 0 0", sb.size(), busy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        hold_w = 1'b0; req_valid_w = 4'b0000;
        req_src0_w = '0; req_src1_w = '0;
        test_reset();
        test_single();
        test_all_four();
        test_ptr2();
        test_hold();
        test_reset_mid();
        test_wide();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
